// File: rtl/muldiv_controller.sv
// HI/LO multiply/divide sequencer for the EX stage.
// Fixed-latency multiply, 32-step restoring divide, flush-cancellable.
module muldiv_controller #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [4:0]  dcnt_q, dcnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;
  logic        dz_q, dz_d;

  logic        legal;
  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;
  logic        sgn_mul;
  logic        sgn_div;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  assign legal   = ~(req_op[2] & req_op[1]);
  assign accept  = req_valid & req_ready & ~flush & legal;

  assign is_mul  = (req_op == OP_MULT) | (req_op == OP_MULTU);
  assign is_div  = (req_op == OP_DIV) | (req_op == OP_DIVU);
  assign is_mthi = (req_op == OP_MTHI);
  assign is_mtlo = (req_op == OP_MTLO);
  assign sgn_mul = (req_op == OP_MULT);
  assign sgn_div = (req_op == OP_DIV);

  assign ext_a = {{32{sgn_mul & req_a[31]}}, req_a};
  assign ext_b = {{32{sgn_mul & req_b[31]}}, req_b};

  assign a_neg = sgn_div & req_a[31];
  assign b_neg = sgn_div & req_b[31];
  assign a_mag = a_neg ? (~req_a + 32'd1) : req_a;
  assign b_mag = b_neg ? (~req_b + 32'd1) : req_b;

  // Remainder stays below the divisor, so 32 bits hold it between steps
  assign shifted = {rem_q, dvd_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};

  assign quo_fix = qsign_q ? (~dvd_q + 32'd1) : dvd_q;
  assign rem_fix = rsign_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    mcnt_d  = mcnt_q;
    dcnt_d  = dcnt_q;
    prod_d  = prod_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    dz_d    = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mthi: hi_d = req_a;
            is_mtlo: lo_d = req_a;
            is_mul: begin
              prod_d  = ext_a * ext_b;
              mcnt_d  = MUL_LAST;
              state_d = S_MUL;
            end
            is_div: begin
              dvd_d   = a_mag;
              dvs_d   = b_mag;
              rem_d   = 32'd0;
              qsign_d = a_neg ^ b_neg;
              rsign_d = a_neg;
              dz_d    = (req_b == 32'd0);
              dcnt_d  = 5'd0;
              state_d = S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (mcnt_q == 4'd0) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          mcnt_d = mcnt_q - 4'd1;
        end
      end
      S_DIV: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        dcnt_d = dcnt_q + 5'd1;
        if (dcnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!dz_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
        done_d  = 1'b1;
        dcnt_d  = 5'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over any final write and any same-cycle accept
    if (flush) begin
      state_d = S_IDLE;
      mcnt_d  = 4'd0;
      dcnt_d  = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      mcnt_q  <= 4'd0;
      dcnt_q  <= 5'd0;
      prod_q  <= 64'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      mcnt_q  <= mcnt_d;
      dcnt_q  <= dcnt_d;
      prod_q  <= prod_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed-vector bench for muldiv_controller.
// Table of ops plus hand sequences for flush, reset and back-to-back.
module tb_muldiv_controller;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vt[16];

  muldiv_controller #(.MUL_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  task automatic wait_done(input string nm, input int lat);
    int  nb;
    bit  seen;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(lat));
    chk({nm, "_ready_at_done"}, 64'(req_ready), 64'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    drive(v.op, v.a, v.b);
    chk({nm, "_ready_pre"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.lat == 0) begin
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd0);
      chk({nm, "_hi"}, 64'(hi), 64'(v.hi));
      chk({nm, "_lo"}, 64'(lo), 64'(v.lo));
    end else begin
      chk({nm, "_hold_hilo"}, {hi, lo}, {cur_hi, cur_lo});
      wait_done(nm, v.lat);
      chk({nm, "_hi"}, 64'(hi), 64'(v.hi));
      chk({nm, "_lo"}, 64'(lo), 64'(v.lo));
      @(negedge clk);
      chk({nm, "_done_pulse"}, 64'(done), 64'd0);
    end
    cur_hi = v.hi;
    cur_lo = v.lo;
  endtask

  initial begin
    vt[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 4};
    vt[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 4};
    vt[2]  = '{3'd0, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h00000000, 4};
    vt[3]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 4};
    vt[4]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vt[5]  = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 33};
    vt[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000, 33};
    vt[7]  = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vt[8]  = '{3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 33};
    vt[9]  = '{3'd4, 32'h11, 32'd0, 32'h11, 32'd14, 0};
    vt[10] = '{3'd5, 32'h22, 32'd0, 32'h11, 32'h22, 0};
    vt[11] = '{3'd3, 32'd5, 32'd0, 32'h11, 32'h22, 33};
    vt[12] = '{3'd4, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'h22, 0};
    vt[13] = '{3'd5, 32'h12345678, 32'd0,
               32'hDEADBEEF, 32'h12345678, 0};
    vt[14] = '{3'd6, 32'hFFFFFFFF, 32'd1,
               32'hDEADBEEF, 32'h12345678, 0};
    vt[15] = '{3'd7, 32'hFFFFFFFF, 32'd1,
               32'hDEADBEEF, 32'h12345678, 0};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    flush     = 1'b0;
    cur_hi    = 32'd0;
    cur_lo    = 32'd0;

    #2;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec(i, vt[i]);

    // DIV flushed at E10, then MULTU accepted right away
    drive(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("fl_div_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_div_busy_after", 64'(busy), 64'd0);
    chk("fl_div_ready", 64'(req_ready), 64'd1);
    chk("fl_div_done", 64'(done), 64'd0);
    chk("fl_div_hilo", {hi, lo}, {cur_hi, cur_lo});
    run_vec(16, '{3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 4});

    // Flush discards a same-cycle request
    drive(3'd4, 32'hAAAA5555, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    chk("fl_req_hi", 64'(hi), 64'd0);
    chk("fl_req_busy", 64'(busy), 64'd0);

    // Flush on the MUL write edge
    drive(3'd0, 32'd3, 32'd5);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("fl_mul_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_mul_done", 64'(done), 64'd0);
    chk("fl_mul_busy_after", 64'(busy), 64'd0);
    chk("fl_mul_hilo", {hi, lo}, {32'd0, 32'd42});
    @(negedge clk);
    chk("fl_mul_done2", 64'(done), 64'd0);
    chk("fl_mul_hilo2", {hi, lo}, {32'd0, 32'd42});

    // Asynchronous reset during DIV step 20
    drive(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("ar_busy_pre", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_hilo", {hi, lo}, 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    cur_hi = 32'd0;
    cur_lo = 32'd0;

    // DIVU then MULTU accepted in the done cycle
    drive(3'd3, 32'd9, 32'd4);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done("b2b_divu", 33);
    chk("b2b_divu_hilo", {hi, lo}, {32'd1, 32'd2});
    drive(3'd1, 32'd6, 32'd7);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_accept_busy", 64'(busy), 64'd1);
    chk("b2b_accept_done", 64'(done), 64'd0);
    chk("b2b_hold", {hi, lo}, {32'd1, 32'd2});
    wait_done("b2b_mul", 4);
    chk("b2b_mul_hilo", {hi, lo}, {32'd0, 32'd42});
    @(negedge clk);
    chk("b2b_done_pulse", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_controller.md
# muldiv_controller

Sequencing controller for the HI/LO multiply/divide resource in the EX stage. Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time from the ALU, runs a fixed-latency multiply or a 32-iteration restoring divide, and owns the architectural HI/LO registers. Provides a busy/stall indication to the pipeline and a one-cycle completion pulse. A pipeline flush cancels an in-flight operation without touching HI/LO.

## Interface
- MUL_CYCLES, 4: edges from accept to HI/LO write for MULT/MULTU; legal range 1..15.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present this cycle.
- req_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored, never accepted.
- req_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- req_b  in  32  rt operand (divisor / multiplier).
- req_ready  out  1  1 only in IDLE; combinational from state.
- flush  in  1  cancel in-flight operation and discard any same-cycle request.
- busy  out  1  state != IDLE; used as EX stall.
- done  out  1  one-cycle pulse: HI/LO just updated by a MULT/MULTU/DIV/DIVU.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Accept = req_valid & req_ready & !flush & legal op.
- IDLE, accept MTHI/MTLO: HI (resp. LO) <= req_a at that edge; stays IDLE; no done, no busy.
- IDLE, accept MULT/MULTU: product captured from operands (signed 32x32->64 for MULT, unsigned for MULTU); counter <= MUL_CYCLES-1; -> MUL (if MUL_CYCLES==1, write happens from MUL on the next edge, i.e. total 1 edge counted from accept: accept edge loads, next edge writes — see Timing).
- MUL: counter decrements each edge; at counter==0 edge, {hi,lo} <= product, -> IDLE, done=1 next cycle.
- IDLE, accept DIV/DIVU: load magnitudes (DIV: |a|, |b| via two's complement when bit31 set; DIVU: raw), record qsign = a31^b31, rsign = a31 (both 0 for DIVU), divzero = (b==0), iteration counter <= 0; -> DIV.
- DIV: one restoring shift-subtract step per edge, 33-bit partial remainder; after 32nd step -> FIX.
- FIX: negate quotient if qsign, remainder if rsign; if divzero, HI/LO unchanged, else lo <= quotient, hi <= remainder; -> IDLE; done pulses (also pulses when divzero).
- 0x80000000 / 0xFFFFFFFF (DIV): magnitude quotient 0x80000000, negated stays 0x80000000, remainder 0; no special case.
- flush: at any edge, state -> IDLE, counters cleared, no HI/LO write, no done; overrides the final write edge of MUL or FIX and a same-cycle accept.
- Reset: state IDLE, hi=0, lo=0, done=0, busy=0, req_ready=1, internal operand/counter registers 0.

## Timing
- Accept at edge E0. MULT/MULTU: HI/LO written at edge E0+MUL_CYCLES; busy high cycles E0..E0+MUL_CYCLES-1 (after each edge, before the write edge); done high for the cycle after the write edge; req_ready high again same cycle as done.
- DIV/DIVU: steps at E1..E32, FIX write at E33; busy for 33 cycles; done in cycle after E33.
- Back-to-back: a new request may be accepted in the done cycle (state already IDLE).
- MTHI/MTLO result visible on hi/lo the cycle after accept; zero stall.
- hi/lo change only at accept of MTHI/MTLO, the MUL final edge, or FIX edge.
- Reset deasserting mid-cycle has no effect until the next rising edge; asserting mid-operation aborts immediately.

## Test plan
- MULT a=0xFFFFFFFE, b=3 -> after 4 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle, busy 4 cycles; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done in cycle after E33; DIVU same -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 with prior hi=0x11, lo=0x22 -> hi/lo unchanged, done pulses at E33.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> both accepted, busy never asserted, hi/lo updated; req_valid with req_op=110 -> req_ready 1 but nothing changes.
- DIV 100/7 with flush at E10 -> no done, hi/lo unchanged, req_ready=1 next cycle; MULTU 6*7 accepted immediately -> lo=42, hi=0; flush coincident with MUL final edge -> no write, no done.
- rst low during DIV step 20 -> hi=lo=0, busy=0, done=0 immediately (asynchronous); after release, DIVU 9/4 -> lo=2, hi=1.
